abs_enc_adc_emulator: RTL



---
 rtl/abs_enc_adc_emulator.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/abs_enc_adc_emulator.sv
// Device-side emulator of a dual 8-channel 16-bit parallel ADC, backed by a host-loaded shadow bank.
// Optional build macro ABS_ENC_EMU_RAMP_EN: per-channel shadow ramp applied after every commit.
module abs_enc_adc_emulator #(
    parameter int CONV_CYCLES = 20,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_rst,
    input  logic              convst,
    input  logic              cs0_n,
    input  logic              cs1_n,
    output logic              busy0,
    output logic [DATA_W-1:0] data_out,
    input  logic              ld_valid,
    input  logic [3:0]        ld_ch,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ovr,
    input  logic              ovr_clr,
    output logic [15:0]       conv_cnt
);

    localparam int NCH = 16;

    typedef enum logic [1:0] {
        ST_RST,
        ST_IDLE,
        ST_CONV
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        busy_cnt_q, busy_cnt_d;
    logic              busy0_q, busy0_d;
    logic              ovr_q, ovr_d;
    logic [15:0]       conv_cnt_q, conv_cnt_d;
    logic [2:0]        ptr0_q, ptr0_d;
    logic [2:0]        ptr1_q, ptr1_d;
    logic              convst_r_q, cs0_r_q, cs1_r_q;
    logic [DATA_W-1:0] shadow_q [NCH];
    logic [DATA_W-1:0] shadow_d [NCH];
    logic [DATA_W-1:0] bank_q   [NCH];
    logic [DATA_W-1:0] bank_d   [NCH];

    logic convst_rise;
    logic cs0_rise;
    logic cs1_rise;
    logic commit;
    logic clear_bank;

    assign convst_rise = convst & ~convst_r_q;
    assign cs0_rise    = cs0_n & ~cs0_r_q;
    assign cs1_rise    = cs1_n & ~cs1_r_q;
    assign commit      = (state_q == ST_CONV) && !enc_rst && (busy_cnt_q == 8'd0);
    assign clear_bank  = enc_rst || (state_q == ST_RST);

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        busy0_d    = busy0_q;
        ovr_d      = ovr_q;
        conv_cnt_d = conv_cnt_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (enc_rst) begin
            state_d    = ST_RST;
            busy0_d    = 1'b0;
            busy_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_RST: begin
                    state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (convst_rise) begin
                        state_d    = ST_CONV;
                        busy0_d    = 1'b1;
                        busy_cnt_d = 8'(CONV_CYCLES - 1);
                    end
                end
                ST_CONV: begin
                    // A second start during conversion never restarts it; set beats clear.
                    if (convst_rise) begin
                        ovr_d = 1'b1;
                    end
                    if (busy_cnt_q == 8'd0) begin
                        state_d    = ST_IDLE;
                        busy0_d    = 1'b0;
                        conv_cnt_d = conv_cnt_q + 16'd1;
                    end else begin
                        busy_cnt_d = busy_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ptr0_d = ptr0_q + 3'(cs0_rise);
        ptr1_d = ptr1_q + 3'(cs1_rise);
        if (clear_bank || commit) begin
            ptr0_d = 3'd0;
            ptr1_d = 3'd0;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic              ld_hit;
            logic [DATA_W-1:0] shadow_upd;

            assign ld_hit = ld_valid && (ld_ch == 4'(gi));
`ifdef ABS_ENC_EMU_RAMP_EN
            assign shadow_upd = commit ? (shadow_q[gi] + DATA_W'(gi + 1)) : shadow_q[gi];
`else
            assign shadow_upd = shadow_q[gi];
`endif
            // Output bank takes the pre-write shadow value when a load lands in the commit cycle.
            assign shadow_d[gi] = ld_hit ? ld_data : shadow_upd;
            assign bank_d[gi]   = clear_bank ? '0 : (commit ? shadow_q[gi] : bank_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_cnt_q <= 8'd0;
            busy0_q    <= 1'b0;
            ovr_q      <= 1'b0;
            conv_cnt_q <= 16'd0;
            ptr0_q     <= 3'd0;
            ptr1_q     <= 3'd0;
            convst_r_q <= 1'b0;
            // Strobe history starts deasserted so leaving reset is not seen as a read end.
            cs0_r_q    <= 1'b1;
            cs1_r_q    <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                bank_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            busy0_q    <= busy0_d;
            ovr_q      <= ovr_d;
            conv_cnt_q <= conv_cnt_d;
            ptr0_q     <= ptr0_d;
            ptr1_q     <= ptr1_d;
            convst_r_q <= convst;
            cs0_r_q    <= cs0_n;
            cs1_r_q    <= cs1_n;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
                bank_q[i]   <= bank_d[i];
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (!cs0_n) begin
            data_out = bank_q[{1'b0, ptr0_q}];
        end else if (!cs1_n) begin
            data_out = bank_q[{1'b1, ptr1_q}];
        end
    end

    assign busy0    = busy0_q;
    assign ovr      = ovr_q;
    assign conv_cnt = conv_cnt_q;

endmodule
